// File: rtl/hart_scheduler_if.sv
// hart_scheduler_if: issue, completion, memory-ack and launch signals between scheduler and core
interface hart_scheduler_if #(
    parameter int HART_W = 2
);
    logic              issue_valid;
    logic              issue_ready;
    logic [HART_W-1:0] issue_hart;
    logic [31:0]       issue_pc;
    logic              done_valid;
    logic [HART_W-1:0] done_hart;
    logic [31:0]       done_next_pc;
    logic              done_halt;
    logic              done_wait;
    logic              mem_ack_valid;
    logic [HART_W-1:0] mem_ack_hart;
    logic              start_valid;
    logic [HART_W-1:0] start_hart;
    logic [31:0]       start_pc;

    modport master (
        input  issue_valid, issue_hart, issue_pc,
        output issue_ready, done_valid, done_hart, done_next_pc, done_halt, done_wait,
        output mem_ack_valid, mem_ack_hart, start_valid, start_hart, start_pc
    );

    modport slave (
        output issue_valid, issue_hart, issue_pc,
        input  issue_ready, done_valid, done_hart, done_next_pc, done_halt, done_wait,
        input  mem_ack_valid, mem_ack_hart, start_valid, start_hart, start_pc
    );
endinterface

// File: rtl/hart_scheduler.sv
// hart_scheduler: round-robin issue scheduler holding per-hart PC and run state for a barrel core
module hart_scheduler #(
    parameter int          NHARTS   = 4,
    parameter int          HART_W   = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    hart_scheduler_if.slave    bus,
    output logic               halt,
    output logic               protocol_error
);
    typedef enum logic [2:0] {IDLE, READY, RUNNING, WAIT, HALTED} hart_state_t;

    hart_state_t       st   [NHARTS];
    hart_state_t       st_n [NHARTS];
    logic [31:0]       pc   [NHARTS];
    logic [31:0]       pc_n [NHARTS];
    logic [HART_W-1:0] rr_ptr, rr_ptr_n, idx;
    logic              found, xfer, err_n, halt_n;

    // Offer the first READY hart after the last issued one, using registered state only
    always_comb begin
        found = 1'b0;
        idx = '0;
        bus.issue_hart = '0;
        bus.issue_pc = '0;
        for (int i = 1; i <= NHARTS; i++) begin
            idx = rr_ptr + HART_W'(i);
            if (!found && st[idx] == READY) begin
                found = 1'b1;
                bus.issue_hart = idx;
                bus.issue_pc = pc[idx];
            end
        end
        bus.issue_valid = found;
    end

    assign xfer = bus.issue_valid & bus.issue_ready;

    always_comb begin
        rr_ptr_n = xfer ? bus.issue_hart : rr_ptr;
        err_n = protocol_error;
        halt_n = 1'b1;
        for (int h = 0; h < NHARTS; h++) begin
            st_n[h] = st[h];
            pc_n[h] = pc[h];
            if (xfer && bus.issue_hart == HART_W'(h))
                st_n[h] = RUNNING;
            if (bus.done_valid && bus.done_hart == HART_W'(h)) begin
                if (st[h] == RUNNING) begin
                    pc_n[h] = bus.done_next_pc;
                    st_n[h] = bus.done_halt ? HALTED : bus.done_wait ? WAIT : READY;
                end else
                    err_n = 1'b1;
            end
            // Ack is judged on pre-cycle state, so a same-cycle done never legalises it
            if (bus.mem_ack_valid && bus.mem_ack_hart == HART_W'(h)) begin
                if (st[h] == WAIT)
                    st_n[h] = READY;
                else
                    err_n = 1'b1;
            end
            if (bus.start_valid && bus.start_hart == HART_W'(h)) begin
                if (st[h] == IDLE || st[h] == HALTED) begin
                    pc_n[h] = bus.start_pc;
                    st_n[h] = READY;
                end else if (st[h] == READY && !(xfer && bus.issue_hart == HART_W'(h)))
                    pc_n[h] = bus.start_pc;
                else
                    err_n = 1'b1;
            end
            if (st_n[h] == READY || st_n[h] == RUNNING || st_n[h] == WAIT)
                halt_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int h = 0; h < NHARTS; h++) begin
                st[h] <= (h == 0) ? READY : IDLE;
                pc[h] <= RESET_PC;
            end
            rr_ptr <= HART_W'(NHARTS - 1);
            halt <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            for (int h = 0; h < NHARTS; h++) begin
                st[h] <= st_n[h];
                pc[h] <= pc_n[h];
            end
            rr_ptr <= rr_ptr_n;
            halt <= halt_n;
            protocol_error <= err_n;
        end
    end
endmodule

// File: tb/tb_hart_scheduler.sv
// tb_hart_scheduler: directed vectors with hand-computed expectations for hart_scheduler
module tb_hart_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halt, protocol_error;
    int   total = 0;
    int   bad = 0;

    hart_scheduler_if #(.HART_W(2)) bus ();

    hart_scheduler #(.NHARTS(4), .HART_W(2), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .halt(halt),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic offer(input string tag, input logic v, input logic [1:0] h, input logic [31:0] p);
        check({tag, "_valid"}, 32'(bus.issue_valid), 32'(v));
        check({tag, "_hart"}, 32'(bus.issue_hart), 32'(h));
        check({tag, "_pc"}, bus.issue_pc, p);
    endtask

    // Advance one clock, then drop the single-cycle event strobes
    task automatic tick;
        @(posedge clk);
        #1;
        bus.done_valid = 1'b0;
        bus.done_halt = 1'b0;
        bus.done_wait = 1'b0;
        bus.mem_ack_valid = 1'b0;
        bus.start_valid = 1'b0;
    endtask

    task automatic done(input logic [1:0] h, input logic [31:0] p, input logic hl, input logic w);
        bus.done_valid = 1'b1;
        bus.done_hart = h;
        bus.done_next_pc = p;
        bus.done_halt = hl;
        bus.done_wait = w;
    endtask

    task automatic start(input logic [1:0] h, input logic [31:0] p);
        bus.start_valid = 1'b1;
        bus.start_hart = h;
        bus.start_pc = p;
    endtask

    task automatic ack(input logic [1:0] h);
        bus.mem_ack_valid = 1'b1;
        bus.mem_ack_hart = h;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.issue_ready = 1'b0;
        bus.done_hart = '0;
        bus.done_next_pc = '0;
        bus.mem_ack_hart = '0;
        bus.start_hart = '0;
        bus.start_pc = '0;
        tick();
        do_reset();
        offer("rst", 1'b1, 2'd0, 32'h0);
        check("rst_halt", 32'(halt), 32'h0);
        check("rst_perr", 32'(protocol_error), 32'h0);
        bus.issue_ready = 1'b1;
        tick();
        offer("running0", 1'b0, 2'd0, 32'h0);
        done(2'd0, 32'h4, 1'b0, 1'b0);
        tick();
        offer("h0_pc4", 1'b1, 2'd0, 32'h4);
        check("h0_halt", 32'(halt), 32'h0);
        // Round robin across four harts
        start(2'd1, 32'h100);
        tick();
        offer("rr1", 1'b1, 2'd1, 32'h100);
        start(2'd2, 32'h200);
        done(2'd0, 32'h8, 1'b0, 1'b0);
        tick();
        offer("rr2", 1'b1, 2'd2, 32'h200);
        start(2'd3, 32'h300);
        done(2'd1, 32'h104, 1'b0, 1'b0);
        tick();
        offer("rr3", 1'b1, 2'd3, 32'h300);
        done(2'd2, 32'h204, 1'b0, 1'b0);
        tick();
        offer("rr4", 1'b1, 2'd0, 32'h8);
        done(2'd3, 32'h304, 1'b0, 1'b0);
        tick();
        offer("rr5", 1'b1, 2'd1, 32'h104);
        done(2'd0, 32'hC, 1'b0, 1'b0);
        tick();
        // Hart 1 blocks on memory and is skipped until acked
        offer("w0", 1'b1, 2'd2, 32'h204);
        done(2'd1, 32'h108, 1'b0, 1'b1);
        tick();
        offer("w1", 1'b1, 2'd3, 32'h304);
        done(2'd2, 32'h208, 1'b0, 1'b0);
        tick();
        offer("w2", 1'b1, 2'd0, 32'hC);
        done(2'd3, 32'h308, 1'b0, 1'b0);
        tick();
        offer("w_skip", 1'b1, 2'd2, 32'h208);
        ack(2'd1);
        tick();
        offer("w3", 1'b1, 2'd3, 32'h308);
        done(2'd0, 32'h10, 1'b0, 1'b0);
        tick();
        offer("w4", 1'b1, 2'd0, 32'h10);
        done(2'd2, 32'h20C, 1'b0, 1'b0);
        tick();
        offer("w_back", 1'b1, 2'd1, 32'h108);
        // Stall: offer holds while the datapath is not ready
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            offer("stall", 1'b1, 2'd1, 32'h108);
        end
        bus.issue_ready = 1'b1;
        tick();
        offer("post_stall", 1'b1, 2'd2, 32'h20C);
        tick();
        offer("all_run", 1'b0, 2'd0, 32'h0);
        bus.issue_ready = 1'b0;
        // Halt every hart; the last one also raises done_wait, which halt overrides
        done(2'd0, 32'h14, 1'b1, 1'b0);
        tick();
        done(2'd1, 32'h10C, 1'b1, 1'b0);
        tick();
        done(2'd2, 32'h210, 1'b1, 1'b0);
        tick();
        check("halt_early", 32'(halt), 32'h0);
        done(2'd3, 32'h30C, 1'b1, 1'b1);
        tick();
        check("halt_set", 32'(halt), 32'h1);
        offer("halted", 1'b0, 2'd0, 32'h0);
        start(2'd2, 32'h40);
        tick();
        check("halt_clr", 32'(halt), 32'h0);
        offer("relaunch", 1'b1, 2'd2, 32'h40);
        check("perr_clean", 32'(protocol_error), 32'h0);
        // Illegal events
        done(2'd3, 32'h999, 1'b0, 1'b0);
        tick();
        check("perr_done", 32'(protocol_error), 32'h1);
        offer("bad_done", 1'b1, 2'd2, 32'h40);
        ack(2'd2);
        tick();
        check("perr_ack", 32'(protocol_error), 32'h1);
        offer("bad_ack", 1'b1, 2'd2, 32'h40);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        start(2'd2, 32'h500);
        tick();
        offer("bad_start", 1'b0, 2'd0, 32'h0);
        check("perr_sticky", 32'(protocol_error), 32'h1);
        check("bad_halt", 32'(halt), 32'h0);
        // Reset mid-operation
        do_reset();
        offer("rst2", 1'b1, 2'd0, 32'h0);
        check("rst2_perr", 32'(protocol_error), 32'h0);
        check("rst2_halt", 32'(halt), 32'h0);
        start(2'd0, 32'h60);
        tick();
        offer("ready_start", 1'b1, 2'd0, 32'h60);
        check("ready_start_perr", 32'(protocol_error), 32'h0);
        bus.issue_ready = 1'b1;
        start(2'd0, 32'h70);
        tick();
        offer("xfer_start", 1'b0, 2'd0, 32'h0);
        check("xfer_start_perr", 32'(protocol_error), 32'h1);
        bus.issue_ready = 1'b0;
        do_reset();
        check("rst3_perr", 32'(protocol_error), 32'h0);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        done(2'd0, 32'h24, 1'b0, 1'b0);
        ack(2'd0);
        tick();
        check("done_ack_perr", 32'(protocol_error), 32'h1);
        offer("done_ack", 1'b1, 2'd0, 32'h24);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
